// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared encodings and constants for the SD SPI-mode command framer
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC,
    ST_SEND,
    ST_POLL,
    ST_DONE
  } state_e;

  localparam logic [6:0] CRC7_POLY    = 7'h09;
  localparam logic [1:0] START_BITS   = 2'b01;
  localparam logic       STOP_BIT     = 1'b1;
  localparam logic [7:0] DEFAULT_FILL = 8'hFF;
  localparam logic [5:0] FRAME_BITS_M1 = 6'd39;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  // MSB-first CRC7 step: feedback is incoming bit xor current top bit.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// rtl/sd_cmd_framer_if.sv - command, byte-engine and response signals of the framer
interface sd_cmd_framer_if;
  logic        cmd_stb;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_ack;
  logic        tx_stb;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic        rx_stb;
  logic [7:0]  rx_data;
  logic        rsp_stb;
  logic [7:0]  rsp_data;
  logic        rsp_tmo;
  logic        busy;

  modport master (
    input  cmd_stb, cmd_idx, cmd_arg, tx_ack, rx_stb, rx_data,
    output cmd_ack, tx_stb, tx_data, rsp_stb, rsp_data, rsp_tmo, busy
  );

  modport slave (
    output cmd_stb, cmd_idx, cmd_arg, tx_ack, rx_stb, rx_data,
    input  cmd_ack, tx_stb, tx_data, rsp_stb, rsp_data, rsp_tmo, busy
  );
endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - bit-serial CRC7 (x^7+x^3+1) with synchronous clear
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_framer.sv
// rtl/sd_cmd_framer.sv - builds a 48-bit SD command frame, streams it and hunts for R1
module sd_cmd_framer
  import sd_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter logic [7:0]  FILL_BYTE    = DEFAULT_FILL
) (
  input logic              CLOCK50,
  input logic              RESET,
  sd_cmd_framer_if.master  bus
);

  localparam logic [7:0] TMO_LIMIT = RESP_TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [39:0] frame_q, frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        wait_rx_q, wait_rx_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        tx_stb_q, tx_stb_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_stb_q, rsp_stb_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_tmo_q, rsp_tmo_d;
  logic        busy_q, busy_d;

  logic        crc_clr, crc_en;
  logic [6:0]  crc;
  logic        byte_done, load_byte, load_fill;
  logic [7:0]  poll_next;

  // The frame rotates during CRC so it is back in place for sending.
  sd_crc7 u_crc7 (
    .clk    (CLOCK50),
    .rst_n  (RESET),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (frame_q[39]),
    .crc    (crc)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    poll_cnt_d = poll_cnt_q;
    wait_rx_d  = wait_rx_q;
    cmd_ack_d  = 1'b0;
    tx_stb_d   = tx_stb_q;
    tx_data_d  = tx_data_q;
    rsp_stb_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_tmo_d  = rsp_tmo_q;
    busy_d     = busy_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    byte_done  = 1'b0;
    load_byte  = 1'b0;
    load_fill  = 1'b0;
    poll_next  = poll_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_stb) begin
          frame_d    = {START_BITS, bus.cmd_idx, bus.cmd_arg};
          cmd_ack_d  = 1'b1;
          busy_d     = 1'b1;
          crc_clr    = 1'b1;
          bit_cnt_d  = 6'd0;
          byte_cnt_d = 3'd0;
          poll_cnt_d = 8'd0;
          wait_rx_d  = 1'b0;
          rsp_data_d = 8'h00;
          rsp_tmo_d  = 1'b0;
          state_d    = ST_CRC;
        end
      end

      ST_CRC: begin
        crc_en    = 1'b1;
        frame_d   = {frame_q[38:0], frame_q[39]};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == FRAME_BITS_M1) begin
          state_d = ST_SEND;
        end
      end

      ST_SEND, ST_POLL: begin
        // A byte completes on its RX_STB, which may coincide with TX_ACK.
        if (tx_stb_q) begin
          if (bus.tx_ack) begin
            tx_stb_d = 1'b0;
            if (bus.rx_stb) begin
              byte_done = 1'b1;
            end else begin
              wait_rx_d = 1'b1;
            end
          end
        end else if (wait_rx_q) begin
          if (bus.rx_stb) begin
            wait_rx_d = 1'b0;
            byte_done = 1'b1;
          end
        end else if (state_q == ST_SEND) begin
          load_byte = 1'b1;
        end

        if (byte_done) begin
          if (state_q == ST_SEND) begin
            if (byte_cnt_q == 3'd5) begin
              state_d   = ST_POLL;
              load_fill = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
              load_byte  = 1'b1;
            end
          end else if (!bus.rx_data[7]) begin
            rsp_data_d = bus.rx_data;
            rsp_tmo_d  = 1'b0;
            rsp_stb_d  = 1'b1;
            state_d    = ST_DONE;
          end else begin
            poll_next  = (poll_cnt_q == 8'hFF) ? 8'hFF : poll_cnt_q + 8'd1;
            poll_cnt_d = poll_next;
            if (poll_next >= TMO_LIMIT) begin
              rsp_data_d = bus.rx_data;
              rsp_tmo_d  = 1'b1;
              rsp_stb_d  = 1'b1;
              state_d    = ST_DONE;
            end else begin
              load_fill = 1'b1;
            end
          end
        end

        if (load_byte) begin
          tx_stb_d = 1'b1;
          if (byte_cnt_d == 3'd5) begin
            tx_data_d = {crc, STOP_BIT};
          end else begin
            tx_data_d = frame_q[39:32];
            frame_d   = {frame_q[31:0], 8'h00};
          end
        end
        if (load_fill) begin
          tx_stb_d  = 1'b1;
          tx_data_d = FILL_BYTE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK50 or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      frame_q    <= 40'h0;
      bit_cnt_q  <= 6'd0;
      byte_cnt_q <= 3'd0;
      poll_cnt_q <= 8'd0;
      wait_rx_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      tx_stb_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      rsp_stb_q  <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_tmo_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      wait_rx_q  <= wait_rx_d;
      cmd_ack_q  <= cmd_ack_d;
      tx_stb_q   <= tx_stb_d;
      tx_data_q  <= tx_data_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_data_q <= rsp_data_d;
      rsp_tmo_q  <= rsp_tmo_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cmd_ack  = cmd_ack_q;
  assign bus.tx_stb   = tx_stb_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.rsp_stb  = rsp_stb_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_tmo  = rsp_tmo_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb/tb_sd_cmd_framer.sv - directed bench for sd_cmd_framer with hand-computed frames
module tb_sd_cmd_framer;
  import sd_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   last_wait;

  sd_cmd_framer_if bus ();

  sd_cmd_framer #(
    .RESP_TIMEOUT (8),
    .FILL_BYTE    (8'hFF)
  ) dut (
    .CLOCK50 (clk),
    .RESET   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ack"}, bus.cmd_ack, 0);
    chk({tag, "_tx_stb"}, bus.tx_stb, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
    chk({tag, "_rsp_stb"}, bus.rsp_stb, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 8'h00);
    chk({tag, "_rsp_tmo"}, bus.rsp_tmo, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
    bus.cmd_idx = idx;
    bus.cmd_arg = arg;
    bus.cmd_stb = 1'b1;
    @(negedge clk);
    bus.cmd_stb = 1'b0;
  endtask

  // One byte exchange as the engine sees it; returns at the negedge after RX_STB was sampled.
  task automatic tx_byte(input string tag, input logic [7:0] exp, input int ack_dly,
                         input bit same, input logic [7:0] rx);
    int n;
    n = 0;
    while (!bus.tx_stb && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk({tag, "_tx_stb_seen"}, bus.tx_stb, 1);
    chk({tag, "_tx_data"}, bus.tx_data, exp);
    if (ack_dly > 0) begin
      repeat (ack_dly) @(negedge clk);
      chk({tag, "_tx_data_stable"}, bus.tx_data, exp);
    end
    bus.tx_ack = 1'b1;
    if (same) begin
      bus.rx_stb  = 1'b1;
      bus.rx_data = rx;
    end
    @(negedge clk);
    bus.tx_ack = 1'b0;
    bus.rx_stb = 1'b0;
    if (!same) begin
      chk({tag, "_tx_stb_drop"}, bus.tx_stb, 0);
      @(negedge clk);
      bus.rx_stb  = 1'b1;
      bus.rx_data = rx;
      @(negedge clk);
      bus.rx_stb = 1'b0;
    end
  endtask

  logic [7:0] f_cmd0  [6];
  logic [7:0] f_cmd8  [6];
  logic [7:0] f_cmd55 [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_wait   = 0;
    f_cmd0  = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    f_cmd8  = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    f_cmd55 = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
    rst_n       = 1'b0;
    bus.cmd_stb = 1'b0;
    bus.cmd_idx = 6'd0;
    bus.cmd_arg = 32'd0;
    bus.tx_ack  = 1'b0;
    bus.rx_stb  = 1'b0;
    bus.rx_data = 8'hFF;

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // CMD0, slow engine, R1 on third poll
    issue(CMD0, 32'h0);
    chk("c0_cmd_ack", bus.cmd_ack, 1);
    chk("c0_busy_rise", bus.busy, 1);
    @(negedge clk);
    chk("c0_cmd_ack_pulse", bus.cmd_ack, 0);
    repeat (39) @(negedge clk);
    chk("c0_tx_stb_not_yet", bus.tx_stb, 0);
    @(negedge clk);
    chk("c0_tx_stb_first", bus.tx_stb, 1);
    for (int i = 0; i < 6; i++) tx_byte($sformatf("c0_b%0d", i), f_cmd0[i], 3, 1'b0, 8'hFF);
    tx_byte("c0_p0", 8'hFF, 3, 1'b0, 8'hFF);
    tx_byte("c0_p1", 8'hFF, 3, 1'b0, 8'hFF);
    tx_byte("c0_p2", 8'hFF, 3, 1'b0, 8'h01);
    chk("c0_rsp_stb", bus.rsp_stb, 1);
    chk("c0_rsp_data", bus.rsp_data, 8'h01);
    chk("c0_rsp_tmo", bus.rsp_tmo, 0);
    chk("c0_busy_hold", bus.busy, 1);
    @(negedge clk);
    chk("c0_rsp_stb_pulse", bus.rsp_stb, 0);
    chk("c0_busy_fall", bus.busy, 0);
    chk("c0_rsp_data_hold", bus.rsp_data, 8'h01);

    // CMD8 issued in the first cycle BUSY is low; stray CMD_STB during SEND
    issue(CMD8, 32'h0000_01AA);
    chk("c8_cmd_ack_back_to_back", bus.cmd_ack, 1);
    for (int i = 0; i < 6; i++) begin
      tx_byte($sformatf("c8_b%0d", i), f_cmd8[i], 0, 1'b0, 8'hFF);
      if (i == 1) begin
        issue(CMD58, 32'hFFFF_FFFF);
        chk("c8_busy_cmd_ignored", bus.cmd_ack, 0);
      end
    end
    tx_byte("c8_p0", 8'hFF, 0, 1'b0, 8'h01);
    chk("c8_rsp_stb_latency", bus.rsp_stb, 1);
    chk("c8_rsp_data", bus.rsp_data, 8'h01);
    chk("c8_rsp_tmo", bus.rsp_tmo, 0);
    @(negedge clk);
    chk("c8_busy_fall", bus.busy, 0);
    @(negedge clk);

    // CMD0 with TX_ACK and RX_STB together on every byte, card never answers
    issue(CMD0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tx_byte($sformatf("tmo_b%0d", i), f_cmd0[i], 0, 1'b1, 8'hFF);
      if (i > 0) chk($sformatf("tmo_b%0d_no_stall", i), last_wait, 0);
    end
    for (int i = 0; i < 8; i++) begin
      tx_byte($sformatf("tmo_p%0d", i), 8'hFF, 0, 1'b1, 8'hFF);
      chk($sformatf("tmo_p%0d_no_stall", i), last_wait, 0);
    end
    chk("tmo_rsp_stb", bus.rsp_stb, 1);
    chk("tmo_rsp_data", bus.rsp_data, 8'hFF);
    chk("tmo_rsp_tmo", bus.rsp_tmo, 1);
    chk("tmo_no_ninth_poll", bus.tx_stb, 0);
    repeat (3) @(negedge clk);
    chk("tmo_tx_quiet", bus.tx_stb, 0);
    chk("tmo_idle", bus.busy, 0);

    // Reset during byte 3 of SEND, then a clean CMD55
    issue(CMD0, 32'h0);
    for (int i = 0; i < 3; i++) tx_byte($sformatf("rst_b%0d", i), f_cmd0[i], 1, 1'b0, 8'hFF);
    chk("rst_b3_pending", bus.tx_stb, 1);
    chk("rst_b3_data", bus.tx_data, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_values("rst_mid");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_further_tx", bus.tx_stb, 0);
    issue(CMD55, 32'h0);
    chk("c55_cmd_ack", bus.cmd_ack, 1);
    for (int i = 0; i < 6; i++) tx_byte($sformatf("c55_b%0d", i), f_cmd55[i], 1, 1'b0, 8'hFF);
    tx_byte("c55_p0", 8'hFF, 1, 1'b0, 8'h00);
    chk("c55_rsp_stb", bus.rsp_stb, 1);
    chk("c55_rsp_data", bus.rsp_data, 8'h00);
    chk("c55_rsp_tmo", bus.rsp_tmo, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
